// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding, mode constants and default widths for serial bus slaves
package bus_pkg;

  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_MEM_SIZE     = 4096;
  localparam int DEF_READ_LATENCY = 4;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RWAIT,
    SPLIT,
    RDATA
  } state_t;

endpackage

// File: rtl/split_slave_mem.sv
// rtl/split_slave_mem.sv - single-port synchronous RAM, registered read, out-of-range reads as zero
module split_slave_mem #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 4096
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  in_range;

  assign in_range = 32'(addr) < MEM_SIZE;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = in_range ? mem[addr[IW-1:0]] : '0;
  end

  // Memory contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we && in_range) mem[addr[IW-1:0]] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/split_serial_slave.sv
// rtl/split_serial_slave.sv - split-capable serial bus slave with local memory
// Define SPLIT_SLAVE_SPLIT_EN to release the bus during reads and resume on split_grant.
module split_serial_slave
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MEM_SIZE     = DEF_MEM_SIZE,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic clk,
  input  logic rstn,
  input  logic swdata,
  input  logic smode,
  input  logic mvalid,
  output logic srdata,
  output logic svalid,
  output logic sready,
  output logic ssplit,
  input  logic split_grant
);

  localparam int CMAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(CMAX);
  localparam int LW   = $clog2(READ_LATENCY + 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic                  sready_q, sready_d;
  logic                  svalid_q, svalid_d;
  logic                  srdata_q, srdata_d;
  logic                  ssplit_q, ssplit_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
`ifdef SPLIT_SLAVE_SPLIT_EN
  logic                  granted_q, granted_d;
`else
  logic                  unused_split_grant;
  assign unused_split_grant = split_grant;
`endif

  split_slave_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) u_mem (
    .clk  (clk),
    .we   (wr_pend_q),
    .re   (state_q == RWAIT),
    .addr (addr_q),
    .wdata(sh_q),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    sready_d  = sready_q;
    svalid_d  = svalid_q;
    srdata_d  = srdata_q;
    ssplit_d  = 1'b0;
    wr_pend_d = 1'b0;
`ifdef SPLIT_SLAVE_SPLIT_EN
    granted_d = granted_q;
`endif
    case (state_q)
      IDLE: begin
        sready_d = 1'b1;
        if (mvalid) begin
          addr_d   = {swdata, addr_q[ADDR_WIDTH-1:1]};
          mode_d   = smode;
          cnt_d    = CW'(1);
          sready_d = 1'b0;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (mvalid) begin
          addr_d = {swdata, addr_q[ADDR_WIDTH-1:1]};
          if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
            cnt_d   = '0;
            lat_d   = '0;
            state_d = (mode_q == WRITE) ? WDATA : RWAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WDATA: begin
        // One extra cycle after the last bit so the full word reaches the RAM.
        if (wr_pend_q) begin
          state_d  = IDLE;
          sready_d = 1'b1;
          cnt_d    = '0;
        end else if (mvalid) begin
          sh_d = {swdata, sh_q[DATA_WIDTH-1:1]};
          if (cnt_q == CW'(DATA_WIDTH - 1)) wr_pend_d = 1'b1;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      RWAIT: begin
        lat_d = lat_q + 1'b1;
`ifdef SPLIT_SLAVE_SPLIT_EN
        if (lat_q == '0) ssplit_d = 1'b1;
`endif
        if (lat_q == LW'(READ_LATENCY)) begin
          lat_d = '0;
          cnt_d = '0;
`ifdef SPLIT_SLAVE_SPLIT_EN
          state_d   = SPLIT;
          sh_d      = mem_rdata;
          granted_d = split_grant;
`else
          state_d  = RDATA;
          svalid_d = 1'b1;
          srdata_d = mem_rdata[0];
          sh_d     = mem_rdata >> 1;
`endif
        end
      end
`ifdef SPLIT_SLAVE_SPLIT_EN
      SPLIT: begin
        if (granted_q) begin
          state_d   = RDATA;
          svalid_d  = 1'b1;
          srdata_d  = sh_q[0];
          sh_d      = sh_q >> 1;
          granted_d = 1'b0;
        end else begin
          granted_d = split_grant;
        end
      end
`endif
      RDATA: begin
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d  = IDLE;
          svalid_d = 1'b0;
          srdata_d = 1'b0;
          sready_d = 1'b1;
          cnt_d    = '0;
        end else begin
          srdata_d = sh_q[0];
          sh_d     = sh_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        sready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      mode_q    <= READ;
      sh_q      <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      sready_q  <= 1'b1;
      svalid_q  <= 1'b0;
      srdata_q  <= 1'b0;
      ssplit_q  <= 1'b0;
      wr_pend_q <= 1'b0;
`ifdef SPLIT_SLAVE_SPLIT_EN
      granted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      sready_q  <= sready_d;
      svalid_q  <= svalid_d;
      srdata_q  <= srdata_d;
      ssplit_q  <= ssplit_d;
      wr_pend_q <= wr_pend_d;
`ifdef SPLIT_SLAVE_SPLIT_EN
      granted_q <= granted_d;
`endif
    end
  end

  assign sready = sready_q;
  assign svalid = svalid_q;
  assign srdata = srdata_q;
  assign ssplit = ssplit_q;

endmodule

// File: tb/tb_split_serial_slave.sv
// tb/tb_split_serial_slave.sv - directed self-checking bench for split_serial_slave
module tb_split_serial_slave;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MS = 2048;
  localparam int RL = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic swdata = 1'b0;
  logic smode = 1'b0;
  logic mvalid = 1'b0;
  logic split_grant = 1'b0;
  logic srdata, svalid, sready, ssplit;
  logic [7:0] d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  split_serial_slave #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_SIZE    (MS),
    .READ_LATENCY(RL)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .swdata     (swdata),
    .smode      (smode),
    .mvalid     (mvalid),
    .srdata     (srdata),
    .svalid     (svalid),
    .sready     (sready),
    .ssplit     (ssplit),
    .split_grant(split_grant)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] v, input int n, input int gap, input logic m);
    for (int i = 0; i < n; i++) begin
      mvalid = 1'b1;
      swdata = v[i];
      smode  = m;
      step();
      mvalid = 1'b0;
      swdata = 1'b0;
      smode  = 1'b0;
      if (i < n - 1) repeat (gap) step();
    end
  endtask

  task automatic write_word(input logic [11:0] a, input logic [7:0] w, input int gap);
    send({20'h0, a}, AW, gap, 1'b1);
    chk("wr_sready_after_addr", {31'h0, sready}, 32'h0);
    send({24'h0, w}, DW, gap, 1'b0);
    chk("wr_sready_last_bit", {31'h0, sready}, 32'h0);
    step();
    chk("wr_sready_return", {31'h0, sready}, 32'h1);
  endtask

  task automatic read_word(input logic [11:0] a, input int gap, input bit noise, output logic [7:0] r);
    send({20'h0, a}, AW, gap, 1'b0);
    chk("rd_sready_busy", {31'h0, sready}, 32'h0);
`ifdef SPLIT_SLAVE_SPLIT_EN
    for (int k = 1; k <= RL + 1; k++) begin
      if (noise) begin mvalid = 1'b1; swdata = 1'b1; end
      step();
      mvalid = 1'b0; swdata = 1'b0;
      chk("rd_ssplit_pulse", {31'h0, ssplit}, {31'h0, k == 1});
      chk("rd_wait_svalid", {31'h0, svalid}, 32'h0);
    end
    repeat (20 - (RL + 1)) begin
      step();
      chk("rd_split_hold_svalid", {31'h0, svalid}, 32'h0);
      chk("rd_split_hold_ssplit", {31'h0, ssplit}, 32'h0);
    end
    split_grant = 1'b1;
    step();
    split_grant = 1'b0;
    chk("rd_grant_edge_svalid", {31'h0, svalid}, 32'h0);
    step();
`else
    for (int k = 1; k <= RL; k++) begin
      if (noise) begin mvalid = 1'b1; swdata = 1'b1; end
      step();
      mvalid = 1'b0; swdata = 1'b0;
      chk("rd_wait_svalid", {31'h0, svalid}, 32'h0);
      chk("rd_wait_ssplit", {31'h0, ssplit}, 32'h0);
    end
    step();
`endif
    chk("rd_first_svalid", {31'h0, svalid}, 32'h1);
    r[0] = srdata;
    for (int i = 1; i < DW; i++) begin
      if (noise) mvalid = 1'b1;
      step();
      mvalid = 1'b0;
      chk("rd_svalid_run", {31'h0, svalid}, 32'h1);
      r[i] = srdata;
    end
    step();
    chk("rd_svalid_end", {31'h0, svalid}, 32'h0);
    chk("rd_sready_end", {31'h0, sready}, 32'h1);
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) step();
    chk("rst_sready", {31'h0, sready}, 32'h1);
    chk("rst_svalid", {31'h0, svalid}, 32'h0);
    chk("rst_srdata", {31'h0, srdata}, 32'h0);
    chk("rst_ssplit", {31'h0, ssplit}, 32'h0);
    rstn = 1'b1;
    step();
    chk("idle_sready", {31'h0, sready}, 32'h1);

    // Basic write then immediate back-to-back read.
    write_word(12'h003, 8'hA5, 0);
    read_word(12'h003, 0, 1'b0, d);
    chk("rd_003_a5", {24'h0, d}, 32'hA5);

    // Gapped write, gapless read with ignored mvalid noise, then gapped read.
    write_word(12'h7C1, 8'h5A, 3);
    read_word(12'h7C1, 0, 1'b1, d);
    chk("rd_7c1_gapped_wr", {24'h0, d}, 32'h5A);
    read_word(12'h003, 3, 1'b0, d);
    chk("rd_003_gapped_rd", {24'h0, d}, 32'hA5);

    // 0xFFF is out of range and must not alias onto 0x7FF.
    write_word(12'h7FF, 8'h11, 0);
    write_word(12'hFFF, 8'hFF, 0);
    read_word(12'hFFF, 0, 1'b0, d);
    chk("rd_fff_oor", {24'h0, d}, 32'h00);
    read_word(12'h7FF, 0, 1'b0, d);
    chk("rd_7ff_no_alias", {24'h0, d}, 32'h11);

    // Reset after 4 of 8 data bits leaves the old word intact.
    write_word(12'h010, 8'h3C, 0);
    send({20'h0, 12'h010}, AW, 0, 1'b1);
    send({24'h0, 8'hC3}, 4, 0, 1'b0);
    rstn = 1'b0;
    step();
    chk("midrst_sready", {31'h0, sready}, 32'h1);
    chk("midrst_svalid", {31'h0, svalid}, 32'h0);
    chk("midrst_srdata", {31'h0, srdata}, 32'h0);
    chk("midrst_ssplit", {31'h0, ssplit}, 32'h0);
    rstn = 1'b1;
    step();
    read_word(12'h010, 0, 1'b0, d);
    chk("rd_010_old", {24'h0, d}, 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/split_serial_slave.md
# split_serial_slave

Split-capable serial bus responder with local memory. It occupies a slave port of the 2-master/3-slave serial bus, including the slave-3 position whose split input is currently tied to 0. It deserializes address and write data from the bus, performs a memory access with programmable read latency, and serializes read data back. Long reads can optionally release the bus with a split and resume only after the arbiter returns `split_grant`.

## Interface
- `ADDR_WIDTH`, 12, slave-local address bits received serially.
- `DATA_WIDTH`, 8, data word bits.
- `MEM_SIZE`, 4096, implemented words. Addresses at or above this value are out of range.
- `READ_LATENCY`, 4, cycles from address capture to read data available. Must be at least 1.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `swdata`  in  1  serial address/write-data bit, LSB first.
- `smode`  in  1  0 = read, 1 = write. Sampled with the first address bit.
- `mvalid`  in  1  `swdata` bit valid.
- `srdata`  out  1  serial read-data bit, LSB first.
- `svalid`  out  1  `srdata` bit valid.
- `sready`  out  1  idle; able to accept a new transaction.
- `ssplit`  out  1  one-cycle pulse: read transaction split, bus released.
- `split_grant`  in  1  bus returned to this slave for split completion.

## Operation
- Reset values: `sready`=1, `svalid`=0, `srdata`=0, `ssplit`=0, state IDLE, bit counter 0. Memory contents are not reset.
- **IDLE**: `sready`=1.
  - `mvalid`=1 → capture address bit 0, latch `smode`, go to ADDR.
  - `sready`=0 from the next cycle.
- **ADDR**: shift one bit per cycle with `mvalid`=1. Cycles with `mvalid`=0 hold the shift state (gaps allowed).
  - After bit `ADDR_WIDTH`-1: write → WDATA; read → RWAIT.
- **WDATA**: shift `DATA_WIDTH` bits, same gap rule.
  - On the last bit, `mem[addr]` is written on the following edge, then state → IDLE.
  - Out-of-range address: write discarded, handshake unchanged.
- **RWAIT**: latency counter runs `READ_LATENCY` cycles. The memory read is issued here.
  - Out-of-range address returns all zeros.
  - Counter expiry → RDATA, or SPLIT when split is enabled.
- **SPLIT** (split only): data held in the shift register. Stay until `split_grant` is sampled 1, then → RDATA.
- **RDATA**: `svalid`=1 for exactly `DATA_WIDTH` consecutive cycles, `srdata` = word LSB first, then → IDLE. No gaps.
- `mvalid` pulses outside IDLE/ADDR/WDATA are ignored.
- Reset asserted mid-transaction: abort immediately to IDLE with reset output values. No partial memory write occurs unless the final data bit was already sampled.

## Timing
- Let t = edge sampling the last address bit of a read.
  - Non-split: `svalid` rises after edge t+`READ_LATENCY`+1.
  - Split: `ssplit`=1 only during the cycle after edge t+1.
  - Split: data is ready after edge t+`READ_LATENCY`+1. With `split_grant` first sampled 1 at edge u ≥ that point, `svalid` rises after edge u+1.
- Write: memory updated at the edge after the last data bit. `sready` returns 1 that same edge.
- `sready` low from the edge after the first address bit until return to IDLE.

## Configuration
- `SPLIT_SLAVE_SPLIT_EN` defined:
  - every read pulses `ssplit` one cycle after address capture and uses the SPLIT state.
  - `split_grant` is honoured.
- Not defined:
  - the SPLIT state is absent and `ssplit` is constant 0.
  - `split_grant` is ignored.
  - the slave holds the bus through RWAIT and goes straight to RDATA.

## Structure
- The shared package `bus_pkg` holds:
  - the state enum (IDLE, ADDR, WDATA, RWAIT, SPLIT, RDATA);
  - the mode constants READ=0 and WRITE=1;
  - the default width constants.
- One sub-module, `split_slave_mem`: single-port synchronous RAM of `MEM_SIZE` × `DATA_WIDTH` with registered read and a range check.

## Test plan
- Write 0xA5 to address 0x003, then read 0x003 without split → `svalid` 8 cycles, serial bits 1,0,1,0,0,1,0,1, first `svalid` at t+5.
- With split: read 0x003 with `split_grant` held 0 for 20 cycles → `ssplit` single pulse at t+2, no `svalid` until one cycle after the grant is sampled, data 0xA5.
- Address and data sent with 3-cycle `mvalid` gaps between bits → same memory contents as the gapless transfer.
- Write 0xFF to 0xFFF with `MEM_SIZE`=2048, then read 0xFFF → returns 0x00, protocol timing normal.
- Reset pulsed during WDATA after 4 data bits → outputs at reset values, subsequent read of that address returns its old value.
- Back-to-back: a read follows immediately when `sready` rises → first address bit accepted on the first `sready`=1 cycle.
